// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory behind valid/ready request and response channels.
// Supports byte-enable writes, programmable wait states and out-of-range flagging.
module data_mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int INIT_ZERO   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0] INIT_WORD = (INIT_ZERO != 0) ? '0 : 'x;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              accept;
    logic              commit;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;

    // With zero wait states the access commits on the accept edge, straight from the request inputs.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_be    = lat_be;
        commit    = (state == ST_WAIT) && (cnt == 4'd1);
        if (WAIT_CYCLES == 0) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
            commit    = accept;
        end
    end

    assign in_range = ({1'b0, acc_addr} < DEPTH_L);
    assign idx      = acc_addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (commit) begin
                rsp_err   <= !in_range;
                rsp_rdata <= (in_range && !acc_we) ? mem[idx] : '0;
            end
        end
    end

    // The array has no reset; a reset during WAIT forces IDLE asynchronously, so commit never fires.
    always_ff @(posedge clk) begin
        if (commit && acc_we && in_range) begin
            for (int k = 0; k < BE_W; k++) begin
                if (acc_be[k]) mem[idx][8*k +: 8] <= acc_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench: unit 0 runs with one wait state, unit 1 with three.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_ready [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] rdata;
    logic        err;
    int          lat;

    data_mem_ctrl #(.DATA_W(32), .DEPTH(512), .ADDR_W(32), .WAIT_CYCLES(1), .INIT_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_ctrl #(.DATA_W(32), .DEPTH(512), .ADDR_W(32), .WAIT_CYCLES(3), .INIT_ZERO(1)) dut3 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One full transaction; lat counts falling edges from the accept edge until rsp_valid.
    task automatic applyStimulus(input int u, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 output logic [31:0] rd, output logic er, output int lt);
        @(negedge clk);
        req_valid[u] = 1'b1;
        req_we[u]    = we;
        req_addr[u]  = addr;
        req_wdata[u] = wdata;
        req_be[u]    = be;
        @(posedge clk);
        #1 req_valid[u] = 1'b0;
        lt = 0;
        do begin
            @(negedge clk);
            lt++;
        end while (!rsp_valid[u] && lt < 40);
        rd = rsp_rdata[u];
        er = rsp_err[u];
        rsp_ready[u] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[u] = 1'b0;
    endtask

    task automatic readCheck(input int u, input logic [31:0] addr, input logic [31:0] expd, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lt;
        applyStimulus(u, 1'b0, addr, 32'h0, 4'h0, rd, er, lt);
        checkOutput({tag, "_rdata"}, rd, expd);
        checkOutput({tag, "_err"}, {31'b0, er}, 32'h0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u]     = 1'b0;
            req_valid[u] = 1'b0;
            req_we[u]    = 1'b0;
            req_addr[u]  = '0;
            req_wdata[u] = '0;
            req_be[u]    = '0;
            rsp_ready[u] = 1'b0;
        end
        #12;
        checkOutput("rst_req_ready", {31'b0, req_ready[0]}, 32'h1);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        checkOutput("rst_rdata", rsp_rdata[0], 32'h0);
        checkOutput("rst_err", {31'b0, rsp_err[0]}, 32'h0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        readCheck(0, 32'd5, 32'h0, "rd5_init");

        applyStimulus(0, 1'b1, 32'd10, 32'hDEADBEEF, 4'hF, rdata, err, lat);
        checkOutput("wr10_latency", 32'(lat), 32'd2);
        checkOutput("wr10_rdata", rdata, 32'h0);
        checkOutput("wr10_err", {31'b0, err}, 32'h0);
        @(negedge clk);
        checkOutput("post_hs_rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        checkOutput("post_hs_req_ready", {31'b0, req_ready[0]}, 32'h1);
        readCheck(0, 32'd10, 32'hDEADBEEF, "rd10_full");

        applyStimulus(0, 1'b1, 32'd10, 32'h11223344, 4'b0101, rdata, err, lat);
        readCheck(0, 32'd10, 32'hDE22BE44, "rd10_be");

        applyStimulus(0, 1'b0, 32'd512, 32'h0, 4'h0, rdata, err, lat);
        checkOutput("rd512_err", {31'b0, err}, 32'h1);
        checkOutput("rd512_rdata", rdata, 32'h0);
        applyStimulus(0, 1'b1, 32'd600, 32'hCAFEF00D, 4'hF, rdata, err, lat);
        checkOutput("wr600_err", {31'b0, err}, 32'h1);
        checkOutput("wr600_rdata", rdata, 32'h0);
        readCheck(0, 32'd88, 32'h0, "rd88_unchanged");
        readCheck(0, 32'd511, 32'h0, "rd511_unchanged");

        // Backpressure: hold the response while a stray write request is offered.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'd10;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[0] && lat < 40);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'd10;
        req_wdata[0] = 32'h0;
        req_be[0]    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rsp_valid", {31'b0, rsp_valid[0]}, 32'h1);
            checkOutput("bp_rdata", rsp_rdata[0], 32'hDE22BE44);
            checkOutput("bp_err", {31'b0, rsp_err[0]}, 32'h0);
            checkOutput("bp_req_ready", {31'b0, req_ready[0]}, 32'h0);
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;
        readCheck(0, 32'd10, 32'hDE22BE44, "rd10_after_bp");

        // Asynchronous reset while a read response is being presented.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'd10;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[0] && lat < 40);
        checkOutput("pre_rst_rdata", rsp_rdata[0], 32'hDE22BE44);
        #2 rst_n[0] = 1'b0;
        #1;
        checkOutput("midrst_req_ready", {31'b0, req_ready[0]}, 32'h1);
        checkOutput("midrst_rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        checkOutput("midrst_rdata", rsp_rdata[0], 32'h0);
        checkOutput("midrst_err", {31'b0, rsp_err[0]}, 32'h0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        readCheck(0, 32'd5, 32'h0, "rd5_after_rst");
        readCheck(0, 32'd10, 32'hDE22BE44, "rd10_after_rst");

        // Three wait states: reset during WAIT must discard the pending write.
        applyStimulus(1, 1'b1, 32'd20, 32'h12345678, 4'hF, rdata, err, lat);
        checkOutput("w3_wr20_latency", 32'(lat), 32'd4);
        readCheck(1, 32'd20, 32'h12345678, "w3_rd20_first");
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'd20;
        req_wdata[1] = 32'hFFFFFFFF;
        req_be[1]    = 4'hF;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        checkOutput("w3_wait_req_ready", {31'b0, req_ready[1]}, 32'h0);
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        checkOutput("w3_rst_req_ready", {31'b0, req_ready[1]}, 32'h1);
        checkOutput("w3_rst_rsp_valid", {31'b0, rsp_valid[1]}, 32'h0);
        checkOutput("w3_rst_rdata", rsp_rdata[1], 32'h0);
        checkOutput("w3_rst_err", {31'b0, rsp_err[1]}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n[1] = 1'b1;
        readCheck(1, 32'd20, 32'h12345678, "w3_rd20_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
